// File: rtl/ff_pkg.sv
// Shared encodings for the universal flip-flop bank: run-time mode codes and
// the SR illegal-input policy codes.
package ff_pkg;

   typedef enum logic [1:0] {
      MODE_SR = 2'b00,
      MODE_JK = 2'b01,
      MODE_D  = 2'b10,
      MODE_T  = 2'b11
   } ff_mode_e;

   localparam int POL_HOLD = 0;
   localparam int POL_SET  = 1;
   localparam int POL_RST  = 2;

endpackage

// File: rtl/ff_next_state.sv
// Single-bit next-state function for the universal flip-flop bank.
// Purely combinational; the register lives in the top level.
module ff_next_state
   import ff_pkg::*;
#(
   parameter int ILLEGAL_POLICY = POL_HOLD
) (
   input  logic       q,
   input  logic       a,
   input  logic       b,
   input  logic [1:0] mode,
   output logic       q_next
);

   logic w_sr_collision_value;

   // The S=R=1 outcome is fixed at elaboration, so it never produces X.
   assign w_sr_collision_value = (ILLEGAL_POLICY == POL_SET) ? 1'b1 :
                                 (ILLEGAL_POLICY == POL_RST) ? 1'b0 : q;

   always_comb begin
      q_next = q;
      unique case (mode)
         MODE_SR: begin
            unique case ({a, b})
               2'b10:   q_next = 1'b1;
               2'b01:   q_next = 1'b0;
               2'b11:   q_next = w_sr_collision_value;
               default: q_next = q;
            endcase
         end
         MODE_JK: begin
            unique case ({a, b})
               2'b10:   q_next = 1'b1;
               2'b01:   q_next = 1'b0;
               2'b11:   q_next = ~q;
               default: q_next = q;
            endcase
         end
         MODE_D:  q_next = a;
         MODE_T:  q_next = q ^ a;
         default: q_next = q;
      endcase
   end

endmodule

// File: rtl/ms_universal_ff_bank.sv
// WIDTH-bit bank of SR/JK/D/T flip-flops with deterministic SR collision
// handling, an illegal-event pulse, a sticky error flag and a saturating counter.
module ms_universal_ff_bank
   import ff_pkg::*;
#(
   parameter int                 WIDTH          = 8,
   parameter logic [WIDTH-1:0]   RESET_VALUE    = '0,
   parameter int                 ILLEGAL_POLICY = POL_HOLD,
   parameter int                 CNT_W          = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [1:0]        mode,
   input  logic [WIDTH-1:0]  a,
   input  logic [WIDTH-1:0]  b,
   input  logic              err_clr,
   output logic [WIDTH-1:0]  q,
   output logic [WIDTH-1:0]  qn,
   output logic              illegal,
   output logic              err_sticky,
   output logic [CNT_W-1:0]  err_cnt
);

   if (ILLEGAL_POLICY < POL_HOLD || ILLEGAL_POLICY > POL_RST) begin : g_bad_policy
      $error("ms_universal_ff_bank: ILLEGAL_POLICY must be 0, 1 or 2");
   end

   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] w_q_next;
   logic             r_illegal;
   logic             r_err_sticky;
   logic [CNT_W-1:0] r_err_cnt;
   logic             w_illegal_evt;
   logic             w_cnt_sat;

   genvar gi;
   for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      ff_next_state #(
         .ILLEGAL_POLICY (ILLEGAL_POLICY)
      ) u_next_state (
         .q      (r_q[gi]),
         .a      (a[gi]),
         .b      (b[gi]),
         .mode   (mode),
         .q_next (w_q_next[gi])
      );
   end

   // One event per cycle no matter how many bits collide.
   assign w_illegal_evt = en && (mode == MODE_SR) && (|(a & b));
   assign w_cnt_sat     = &r_err_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_q          <= RESET_VALUE;
         r_illegal    <= 1'b0;
         r_err_sticky <= 1'b0;
         r_err_cnt    <= '0;
      end else begin
         if (en) begin
            r_q <= w_q_next;
         end
         r_illegal <= w_illegal_evt;
         // A coincident clear restarts the count, then the event is recorded.
         if (w_illegal_evt) begin
            r_err_sticky <= 1'b1;
            if (err_clr) begin
               r_err_cnt <= CNT_W'(1);
            end else if (!w_cnt_sat) begin
               r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
         end else if (err_clr) begin
            r_err_sticky <= 1'b0;
            r_err_cnt    <= '0;
         end
      end
   end

   assign q          = r_q;
   assign qn         = ~r_q;
   assign illegal    = r_illegal;
   assign err_sticky = r_err_sticky;
   assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_ms_universal_ff_bank.sv
// Scoreboard bench: three banks (one per SR policy) share stimulus; a
// behavioural model pushes expected outputs per edge, tasks pop and compare.
module tb_ms_universal_ff_bank;

   localparam logic [3:0] RV = 4'b0101;
   localparam logic [1:0] M_SR = 2'b00, M_JK = 2'b01, M_D = 2'b10, M_T = 2'b11;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [3:0] a = '0;
   logic [3:0] b = '0;
   logic       err_clr = 1'b0;

   logic [3:0] q0, qn0, q1, qn1, q2, qn2;
   logic       ill0, ill1, ill2, st0, st1, st2;
   logic [1:0] cnt0, cnt1, cnt2;

   always #5 clk = ~clk;

   ms_universal_ff_bank #(.WIDTH(4), .RESET_VALUE(RV), .ILLEGAL_POLICY(0), .CNT_W(2)) dut0 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
      .q(q0), .qn(qn0), .illegal(ill0), .err_sticky(st0), .err_cnt(cnt0));
   ms_universal_ff_bank #(.WIDTH(4), .RESET_VALUE(RV), .ILLEGAL_POLICY(1), .CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
      .q(q1), .qn(qn1), .illegal(ill1), .err_sticky(st1), .err_cnt(cnt1));
   ms_universal_ff_bank #(.WIDTH(4), .RESET_VALUE(RV), .ILLEGAL_POLICY(2), .CNT_W(2)) dut2 (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .a(a), .b(b), .err_clr(err_clr),
      .q(q2), .qn(qn2), .illegal(ill2), .err_sticky(st2), .err_cnt(cnt2));

   typedef struct packed {
      logic [3:0] q0;
      logic [3:0] qn0;
      logic [3:0] q1;
      logic [3:0] q2;
      logic       ill;
      logic       st;
      logic [1:0] cnt;
   } obs_t;

   obs_t       sb[$];
   obs_t       exp_o, got_o;
   int         vectors = 0;
   int         miscompares = 0;

   // Reference model state
   logic [3:0] m_q[3];
   logic       m_ill, m_st;
   logic [1:0] m_cnt;

   function automatic logic [3:0] model_next(int pol, logic [3:0] q, logic [3:0] av,
                                             logic [3:0] bv, logic [1:0] m);
      logic [3:0] r;
      r = q;
      for (int i = 0; i < 4; i++) begin
         if (m == M_D) r[i] = av[i];
         else if (m == M_T) r[i] = av[i] ? ~q[i] : q[i];
         else if (av[i] && !bv[i]) r[i] = 1'b1;
         else if (!av[i] && bv[i]) r[i] = 1'b0;
         else if (av[i] && bv[i]) begin
            if (m == M_JK) r[i] = ~q[i];
            else if (pol == 1) r[i] = 1'b1;
            else if (pol == 2) r[i] = 1'b0;
         end
      end
      return r;
   endfunction

   function automatic obs_t observe();
      obs_t o;
      o.q0 = q0; o.qn0 = qn0; o.q1 = q1; o.q2 = q2;
      o.ill = ill0; o.st = st0; o.cnt = cnt0;
      return o;
   endfunction

   // Drive one cycle, push the model's expectation, advance past the edge.
   task automatic apply(input logic r, input logic e, input logic [1:0] m,
                        input logic [3:0] av, input logic [3:0] bv, input logic c);
      logic ev;
      obs_t x;
      rst = r; en = e; mode = m; a = av; b = bv; err_clr = c;
      ev = e && (m == M_SR) && ((av & bv) != 4'h0);
      if (r) begin
         for (int p = 0; p < 3; p++) m_q[p] = RV;
         m_ill = 1'b0; m_st = 1'b0; m_cnt = 2'd0;
      end else begin
         if (e) for (int p = 0; p < 3; p++) m_q[p] = model_next(p, m_q[p], av, bv, m);
         m_ill = ev;
         if (ev) begin
            m_st = 1'b1;
            m_cnt = c ? 2'd1 : ((m_cnt == 2'd3) ? 2'd3 : m_cnt + 2'd1);
         end else if (c) begin
            m_st = 1'b0; m_cnt = 2'd0;
         end
      end
      x.q0 = m_q[0]; x.qn0 = ~m_q[0]; x.q1 = m_q[1]; x.q2 = m_q[2];
      x.ill = m_ill; x.st = m_st; x.cnt = m_cnt;
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      apply(1'b1, 1'b1, M_D, 4'hF, 4'h0, 1'b0);
      exp_o = sb.pop_front(); got_o = observe(); vectors++;
      if (got_o !== exp_o) begin
         miscompares++; $display("FAIL reset_sb got=%h exp=%h", got_o, exp_o);
      end
      vectors++;
      if (got_o.q0 !== 4'b0101 || got_o.qn0 !== 4'b1010 || got_o.cnt !== 2'd0 || got_o.ill !== 1'b0) begin
         miscompares++; $display("FAIL reset_values got q=%h qn=%h cnt=%0d ill=%b exp q=5 qn=a cnt=0 ill=0",
                                 got_o.q0, got_o.qn0, got_o.cnt, got_o.ill);
      end
      $display("reset: q=%h qn=%h cnt=%0d ill=%b", got_o.q0, got_o.qn0, got_o.cnt, got_o.ill);
   endtask

   task automatic test_d_hold();
      apply(1'b0, 1'b1, M_D, 4'hA, 4'h0, 1'b0);
      apply(1'b0, 1'b0, M_D, 4'h3, 4'h0, 1'b0);
      apply(1'b0, 1'b0, M_D, 4'h3, 4'hF, 1'b0);
      for (int i = 0; i < 3; i++) begin
         exp_o = sb.pop_front();
         // Outputs of the earlier cycles are already gone; only the last is live.
         if (i == 2) begin
            got_o = observe(); vectors++;
            if (got_o !== exp_o || got_o.q0 !== 4'hA) begin
               miscompares++; $display("FAIL d_hold got=%h exp=%h (q must be a)", got_o, exp_o);
            end
            $display("d_hold: q=%h", got_o.q0);
         end
      end
   endtask

   task automatic test_jk();
      logic [3:0] want[3];
      want[0] = 4'hF; want[1] = 4'h0; want[2] = 4'hF;
      apply(1'b0, 1'b1, M_D, 4'h0, 4'h0, 1'b0);
      exp_o = sb.pop_front();
      for (int i = 0; i < 3; i++) begin
         apply(1'b0, 1'b1, M_JK, 4'hF, 4'hF, 1'b0);
         exp_o = sb.pop_front(); got_o = observe(); vectors++;
         if (got_o !== exp_o || got_o.q0 !== want[i] || got_o.ill !== 1'b0) begin
            miscompares++; $display("FAIL jk_toggle[%0d] got=%h exp=%h want_q=%h", i, got_o, exp_o, want[i]);
         end
         $display("jk[%0d]: q=%h ill=%b", i, got_o.q0, got_o.ill);
      end
   endtask

   task automatic test_sr_illegal();
      apply(1'b0, 1'b1, M_D, 4'b0101, 4'h0, 1'b0);
      exp_o = sb.pop_front();
      for (int i = 0; i < 5; i++) begin
         apply(1'b0, 1'b1, M_SR, 4'b0011, 4'b0110, 1'b0);
         exp_o = sb.pop_front(); got_o = observe(); vectors++;
         if (got_o !== exp_o) begin
            miscompares++; $display("FAIL sr_illegal[%0d] got=%h exp=%h", i, got_o, exp_o);
         end
         $display("sr[%0d]: q0=%h q1=%h q2=%h ill=%b st=%b cnt=%0d", i, got_o.q0, got_o.q1, got_o.q2,
                  got_o.ill, got_o.st, got_o.cnt);
      end
      vectors++;
      if (got_o.q0 !== 4'b0001 || got_o.q1 !== 4'b0011 || got_o.q2 !== 4'b0001 || got_o.cnt !== 2'd3 || got_o.st !== 1'b1) begin
         miscompares++; $display("FAIL sr_policy_sat got q0=%h q1=%h q2=%h cnt=%0d st=%b exp 1 3 1 3 1",
                                 got_o.q0, got_o.q1, got_o.q2, got_o.cnt, got_o.st);
      end
      apply(1'b0, 1'b0, M_SR, 4'hF, 4'hF, 1'b0);
      exp_o = sb.pop_front(); got_o = observe(); vectors++;
      if (got_o !== exp_o || got_o.ill !== 1'b0 || got_o.cnt !== 2'd3) begin
         miscompares++; $display("FAIL sr_disabled got=%h exp=%h", got_o, exp_o);
      end
      $display("sr_disabled: ill=%b cnt=%0d", got_o.ill, got_o.cnt);
   endtask

   task automatic test_err_clr();
      logic [3:0] q_before;
      apply(1'b0, 1'b1, M_SR, 4'b0011, 4'b0110, 1'b1);
      exp_o = sb.pop_front(); got_o = observe(); vectors++;
      if (got_o !== exp_o || got_o.cnt !== 2'd1 || got_o.st !== 1'b1) begin
         miscompares++; $display("FAIL clr_vs_event got=%h exp=%h (cnt=1 st=1)", got_o, exp_o);
      end
      $display("clr_vs_event: cnt=%0d st=%b", got_o.cnt, got_o.st);
      q_before = got_o.q0;
      apply(1'b0, 1'b0, M_D, 4'hF, 4'h0, 1'b1);
      exp_o = sb.pop_front(); got_o = observe(); vectors++;
      if (got_o !== exp_o || got_o.cnt !== 2'd0 || got_o.st !== 1'b0 || got_o.q0 !== q_before) begin
         miscompares++; $display("FAIL clr_only got=%h exp=%h", got_o, exp_o);
      end
      $display("clr_only: cnt=%0d st=%b q=%h", got_o.cnt, got_o.st, got_o.q0);
   endtask

   task automatic test_back_to_back();
      logic [3:0] want[2];
      want[0] = 4'h9; want[1] = 4'h0;
      apply(1'b0, 1'b1, M_D, 4'h0, 4'h0, 1'b0);
      exp_o = sb.pop_front();
      for (int i = 0; i < 2; i++) begin
         apply(1'b0, 1'b1, M_T, 4'b1001, 4'hF, 1'b0);
         exp_o = sb.pop_front(); got_o = observe(); vectors++;
         if (got_o !== exp_o || got_o.q0 !== want[i]) begin
            miscompares++; $display("FAIL t_toggle[%0d] got=%h exp=%h", i, got_o, exp_o);
         end
         $display("t[%0d]: q=%h", i, got_o.q0);
      end
      apply(1'b0, 1'b1, M_SR, 4'hF, 4'hF, 1'b0);
      exp_o = sb.pop_front();
      apply(1'b1, 1'b1, M_SR, 4'hF, 4'hF, 1'b0);
      exp_o = sb.pop_front(); got_o = observe(); vectors++;
      if (got_o !== exp_o || got_o.q0 !== RV || got_o.ill !== 1'b0 || got_o.cnt !== 2'd0 || got_o.st !== 1'b0) begin
         miscompares++; $display("FAIL rst_mid got=%h exp=%h", got_o, exp_o);
      end
      $display("rst_mid: q=%h ill=%b cnt=%0d", got_o.q0, got_o.ill, got_o.cnt);
   endtask

   task automatic test_random();
      for (int i = 0; i < 60; i++) begin
         apply(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
               4'($urandom), 4'($urandom), ($urandom_range(0, 5) == 0));
         exp_o = sb.pop_front(); got_o = observe(); vectors++;
         if (got_o !== exp_o) begin
            miscompares++; $display("FAIL random[%0d] got=%h exp=%h", i, got_o, exp_o);
         end
         $display("random[%0d]: mode=%0d en=%b q0=%h ill=%b cnt=%0d", i, mode, en, got_o.q0, got_o.ill, got_o.cnt);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_d_hold();
      test_jk();
      test_sr_illegal();
      test_err_clr();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
